// File: rtl/reg_pkg.sv
// Shared definitions for the register pipeline blocks: default data width
// and the occupancy-counter width helper.
package reg_pkg;

    localparam int REG_WIDTH_DEF = 8;

    // Bits needed to hold a value in 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data register pair of the pipeline. The valid bit follows the
// upstream valid whenever the stage is allowed to advance; the data word is
// only captured when the incoming beat is valid, so an empty stage keeps its
// stale word and undriven producer data never enters the register.
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Valid bit: reset and flush both empty the stage; otherwise follow upstream on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= in_valid;
        end
    end

    // Data word: cleared only by reset; flush leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (!clr && load && in_valid) begin
            data <= in_data;
        end
    end

endmodule

// File: rtl/pipe_register_chain.sv
// DEPTH-stage WIDTH-bit register pipeline with valid/ready flow control.
// Ready ripples combinationally from the output back to the input so that
// empty stages (bubbles) are filled as soon as anything upstream can move.
module pipe_register_chain
    import reg_pkg::*;
#(
    parameter  int WIDTH = REG_WIDTH_DEF,
    parameter  int DEPTH = 2,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] stage_vin;
    logic [WIDTH-1:0] stage_din [DEPTH];
    logic [DEPTH:0]   rdy;
    logic             push;
    logic             pop;

    // Ready chain: a stage may advance if it is empty or the stage after it can advance.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !v[i] || rdy[i+1];
        end
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stage_vin[i] = in_valid;
            assign stage_din[i] = in_data;
        end else begin : g_body
            assign stage_vin[i] = v[i-1];
            assign stage_din[i] = d[i-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .clr      (flush),
            .load     (rdy[i]),
            .in_valid (stage_vin[i]),
            .in_data  (stage_din[i]),
            .valid    (v[i]),
            .data     (d[i])
        );
    end

    // Occupancy: tracks push/pop so it always equals the number of valid stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_pipe_register_chain.sv
// Directed checks on a DEPTH=3 chain plus random valid/ready scoreboard lanes
// for DEPTH=1,2,5.
module tb_pipe_register_chain;
    import reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [1:0] count;
    logic       start_rand = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_register_chain #(.WIDTH(8), .DEPTH(3)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [7:0] od, input int cnt);
        chk({tag, "_ov"}, 32'(out_valid), 32'(ov));
        if (ov) chk({tag, "_od"}, 32'(out_data), 32'(od));
        chk({tag, "_cnt"}, 32'(count), 32'(cnt));
    endtask

    // Random lanes: producer holds a beat until accepted; model queue is the reference.
    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int DEP = (g == 0) ? 1 : (g == 1) ? 2 : 5;
        localparam int CW  = cnt_width(DEP);
        logic          l_rst, l_iv, l_ir, l_ov, l_or, l_fl;
        logic [7:0]    l_id, l_od;
        logic [CW-1:0] l_cnt;
        logic          done = 1'b0;

        pipe_register_chain #(.WIDTH(8), .DEPTH(DEP)) u_lane (
            .clk(clk), .rst(l_rst), .flush(l_fl), .in_valid(l_iv), .in_data(l_id),
            .in_ready(l_ir), .out_valid(l_ov), .out_data(l_od),
            .out_ready(l_or), .count(l_cnt)
        );

        initial begin
            logic [7:0] q[$];
            logic       do_push, do_pop;
            logic [7:0] pd, od;
            int         popped = 0;
            int         cyc = 0;
            l_rst = 1'b1; l_fl = 1'b0; l_iv = 1'b0; l_id = '0; l_or = 1'b0;
            while (!start_rand) @(posedge clk);
            repeat (2) tick();
            l_rst = 1'b0;
            while (popped < 10000 && cyc < 60000) begin
                if (!l_iv && $urandom_range(3) != 0) begin
                    l_iv = 1'b1;
                    l_id = 8'($urandom);
                end
                l_or = ($urandom_range(3) != 0);
                #1;
                do_push = l_iv && l_ir;
                do_pop  = l_ov && l_or;
                pd = l_id;
                od = l_od;
                tick();
                cyc++;
                if (do_pop) begin
                    chk("rand_nonempty", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) chk("rand_data", 32'(od), 32'(q.pop_front()));
                    popped++;
                end
                if (do_push) begin
                    q.push_back(pd);
                    l_iv = 1'b0;
                end
                chk("rand_count", 32'(l_cnt), 32'(q.size()));
            end
            chk("rand_timeout", 32'(popped), 32'd10000);
            done = 1'b1;
        end
    end

    initial begin
        int wait_cyc;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk_out("reset", 1'b0, 8'h00, 0);
        chk("reset_od", 32'(out_data), 32'h00);
        chk("reset_ir", 32'(in_ready), 32'd1);

        // 1: three beats, no backpressure
        in_valid = 1'b1;
        in_data = 8'h11; tick();
        chk_out("t1_a", 1'b0, 8'h00, 1);
        in_data = 8'h22; tick();
        chk_out("t1_b", 1'b0, 8'h00, 2);
        in_data = 8'h33; tick();
        chk_out("t1_c", 1'b1, 8'h11, 3);
        in_valid = 1'b0; tick();
        chk_out("t1_d", 1'b1, 8'h22, 2);
        tick();
        chk_out("t1_e", 1'b1, 8'h33, 1);
        tick();
        chk_out("t1_f", 1'b0, 8'h00, 0);
        chk("t1_hold_od", 32'(out_data), 32'h33);

        // 2: backpressure fills the chain, producer holds 0xA4
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hA1; tick();
        in_data = 8'hA2; tick();
        in_data = 8'hA3; tick();
        in_data = 8'hA4; #1;
        chk("t2_full_ir", 32'(in_ready), 32'd0);
        tick();
        chk_out("t2_full", 1'b1, 8'hA1, 3);
        out_ready = 1'b1; #1;
        chk("t2_pp_ir", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk_out("t2_a2", 1'b1, 8'hA2, 3);
        tick();
        chk_out("t2_a3", 1'b1, 8'hA3, 2);
        tick();
        chk_out("t2_a4", 1'b1, 8'hA4, 1);
        tick();
        chk_out("t2_empty", 1'b0, 8'h00, 0);

        // 3: full chain, simultaneous push/pop for 10 cycles
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'hC0 + 8'(k); tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 8'hC3 + 8'(k); #1;
            chk("t3_ir", 32'(in_ready), 32'd1);
            tick();
            chk_out("t3_step", 1'b1, 8'hC1 + 8'(k), 3);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk_out("t3_drain", 1'b0, 8'h00, 0);

        // 4: bubble collapse under backpressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h55; tick();
        in_valid = 1'b0; tick(); tick();
        in_valid = 1'b1; in_data = 8'h66; tick();
        in_valid = 1'b0; tick();
        chk_out("t4_pack", 1'b1, 8'h55, 2);
        chk("t4_ir", 32'(in_ready), 32'd1);

        // 5: flush discards contents and the concurrent input beat
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; #1;
        chk("t5_flush_ir", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk_out("t5_flushed", 1'b0, 8'h00, 0);
        chk("t5_od_kept", 32'(out_data), 32'h55);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h88; tick();
        in_valid = 1'b0;
        chk_out("t5_lat1", 1'b0, 8'h00, 1);
        tick();
        chk_out("t5_lat2", 1'b0, 8'h00, 1);
        tick();
        chk_out("t5_lat3", 1'b1, 8'h88, 1);
        tick();
        chk_out("t5_gone", 1'b0, 8'h00, 0);

        // 6: reset with flush mid-stream, then undriven data with valid low
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hD1; tick();
        in_data = 8'hD2; tick();
        in_data = 8'hD3; tick();
        chk("t6_full_cnt", 32'(count), 32'd3);
        rst = 1'b1; flush = 1'b1; tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; #1;
        chk_out("t6_rst", 1'b0, 8'h00, 0);
        chk("t6_rst_od", 32'(out_data), 32'h00);
        chk("t6_rst_ir", 32'(in_ready), 32'd1);
        in_data = 'x;
        repeat (4) tick();
        chk("t6_x_od", 32'(out_data), 32'h00);
        chk("t6_x_cnt", 32'(count), 32'd0);
        in_data = '0;

        start_rand = 1'b1;
        wait_cyc = 0;
        while (!(g_lane[0].done && g_lane[1].done && g_lane[2].done) && wait_cyc < 70000) begin
            tick();
            wait_cyc++;
        end
        chk("rand_lanes_done", 32'(g_lane[0].done && g_lane[1].done && g_lane[2].done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
